cache_trace_feeder: RTL and testbench
=====================================

CACHE_TRACE_FEEDER -- requirements
Module: cache_trace_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of buffered trace records (power of 2, minimum 2).
REQ-002 Parameter ADDR_W, default 48, sets the trace address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  level; high permits issue to the cache.
REQ-006 in_valid  input  1  upstream record valid.
REQ-007 in_op  input  8  ASCII op: 'R'/'r' is read, 'W'/'w' is write.
REQ-008 in_addr  input  ADDR_W  record address.
REQ-009 in_last  input  1  marks final record of the trace.
REQ-010 in_ready  output  1  feeder accepts the record this cycle.
REQ-011 cache_valid  output  1  cache_addr/cache_op hold a record.
REQ-012 cache_addr  output  ADDR_W  address presented to the cache.
REQ-013 cache_op  output  8  normalized op, 8'h52 ('R') or 8'h57 ('W').
REQ-014 cache_ready  input  1  cache consumes the record this cycle.
REQ-015 issued_reads, issued_writes, bad_ops  output  18 each  event counters.
REQ-016 done  output  1  trace fully issued.

Function
REQ-017 Input handshake: a record is accepted on an edge where in_valid && in_ready.
REQ-018 in_ready SHALL equal (fifo_count < FIFO_DEPTH) && state != DONE, computed from registered state only; there is no same-cycle bypass when full, even if a pop occurs that cycle.
REQ-019 Accepted records with op 8'h52/8'h72 are written to the FIFO as 8'h52; 8'h57/8'h77 as 8'h57.
REQ-020 An accepted record with any other op is dropped, never enters the FIFO, and increments bad_ops.
REQ-021 in_last on any accepted record, valid or dropped, sets a sticky last_seen flag, which is cleared only by reset or by the DONE-to-IDLE transition.
REQ-022 Output register loads from the FIFO head when state is RUN, the FIFO is non-empty, and (!cache_valid || cache_ready).
REQ-023 cache_valid, cache_addr and cache_op SHALL remain stable while cache_valid && !cache_ready.
REQ-024 Issue handshake is cache_valid && cache_ready; on it, issued_reads or issued_writes increments according to cache_op.
REQ-025 If no new record loads on the issue edge, cache_valid clears on that edge.
REQ-026 Latency: a record accepted at edge N into an empty FIFO in RUN state becomes visible on the cache outputs after edge N+1.
REQ-027 Throughput: one record per cycle while cache_ready stays high and the FIFO is non-empty.
REQ-028 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-029 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-030 All counters saturate at 18'h3FFFF and never wrap.
REQ-031 State machine: IDLE -> RUN when enable=1.
REQ-032 RUN -> IDLE when enable=0; the output register holds its current record and the FIFO keeps filling.
REQ-033 RUN -> DONE when last_seen=1, the FIFO is empty, and cache_valid=0 (including clearing this same edge).
REQ-034 DONE -> IDLE when enable=0.
REQ-035 done SHALL be 1 exactly when state is DONE.
REQ-036 Input acceptance is independent of enable, except that it is blocked in DONE.
REQ-037 Counters are not cleared by the state machine; only reset clears them.

Reset
REQ-038 On reset assertion the following take effect immediately, without waiting for clk: state=IDLE, fifo_count=0, pointers=0, last_seen=0, cache_valid=0, cache_addr=0, cache_op=0, all counters=0, done=0, in_ready=0 while reset is high.
REQ-039 Reset asserted mid-transfer discards all buffered and presented records; no counter increments on that edge.
REQ-040 After reset deasserts, in_ready=1 from the first cycle (FIFO empty, state IDLE).

Verification
REQ-041 Single read: enable=1, push ('R', 48'h0000_1234_5678) at edge N with cache_ready=1 -> cache_valid=1 with cache_addr=48'h000012345678 and cache_op=8'h52 after N+1; issued_reads=1 after N+2.
REQ-042 Backpressure: cache_ready=0, push 5 records with FIFO_DEPTH=4 -> in_ready=0 once 4 records are in the FIFO and 1 is in the output register; outputs stable; release cache_ready -> records drain in push order, one per cycle.
REQ-043 Bad op and lowercase: push 'w', then 'X', then 'r' with in_last on 'r' -> bad_ops=1, issued_writes=1, issued_reads=1, cache_op sequence 8'h57 then 8'h52, done=1 one cycle after the final issue.
REQ-044 Last on dropped record: push ('R', A), then ('Z', B) with in_last=1 -> exactly one issue (A), bad_ops=1, then done=1 and in_ready=0; enable=0 -> IDLE, in_ready=1.
REQ-045 Async reset mid-stream: 3 records buffered, cache_valid=1, pulse reset between edges -> cache_valid, counters and fifo_count are 0 before the next edge, and nothing issues afterward.
REQ-046 Saturation: preload issued_writes to 18'h3FFFE via forced state or long run, then issue 3 writes -> issued_writes=18'h3FFFF.

Source files
------------

// File: rtl/cache_trace_feeder_if.sv
// Bundles the upstream trace handshake, the cache issue handshake and the status counters
// of cache_trace_feeder into one interface.
interface cache_trace_feeder_if #(
  parameter int ADDR_W = 48,
  parameter int CNT_W  = 18
);
  logic              enable;
  logic              in_valid;
  logic [7:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic              in_last;
  logic              in_ready;
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_addr;
  logic [7:0]        cache_op;
  logic              cache_ready;
  logic [CNT_W-1:0]  issued_reads;
  logic [CNT_W-1:0]  issued_writes;
  logic [CNT_W-1:0]  bad_ops;
  logic              done;

  modport slave (
    input  enable, in_valid, in_op, in_addr, in_last, cache_ready,
    output in_ready, cache_valid, cache_addr, cache_op,
    output issued_reads, issued_writes, bad_ops, done
  );

  modport master (
    output enable, in_valid, in_op, in_addr, in_last, cache_ready,
    input  in_ready, cache_valid, cache_addr, cache_op,
    input  issued_reads, issued_writes, bad_ops, done
  );
endinterface

// File: rtl/cache_trace_feeder.sv
// Buffers ASCII-op trace records in a small FIFO, normalizes them to 'R'/'W' and issues
// them to a cache through a stall-safe output register, with saturating event counters.
module cache_trace_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 48,
  parameter int CNT_W      = 18
) (
  input logic              clk,
  input logic              reset,
  cache_trace_feeder_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   COUNT_ZERO = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_RL = 8'h72;
  localparam logic [7:0] OP_WL = 8'h77;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]     addr_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] wr_mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  last_q, last_d;
  logic                  cv_q, cv_d;
  logic [ADDR_W-1:0]     caddr_q, caddr_d;
  logic [7:0]            cop_q, cop_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, bad_cnt_q, bad_cnt_d;

  logic in_ready_s, accept_s, op_rd_s, op_wr_s, push_s, pop_s, issue_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Ready depends on registered occupancy only; a same-cycle pop never frees a slot early.
  assign in_ready_s = !reset && (count_q < DEPTH_C) && (state_q != S_DONE);

  assign bus.in_ready      = in_ready_s;
  assign bus.cache_valid   = cv_q;
  assign bus.cache_addr    = caddr_q;
  assign bus.cache_op      = cop_q;
  assign bus.issued_reads  = rd_cnt_q;
  assign bus.issued_writes = wr_cnt_q;
  assign bus.bad_ops       = bad_cnt_q;
  assign bus.done          = (state_q == S_DONE);

  // Datapath next state: FIFO pointers and occupancy, output register and counters.
  always_comb begin
    op_rd_s  = (bus.in_op == OP_R) || (bus.in_op == OP_RL);
    op_wr_s  = (bus.in_op == OP_W) || (bus.in_op == OP_WL);
    accept_s = bus.in_valid && in_ready_s;
    push_s   = accept_s && (op_rd_s || op_wr_s);
    issue_s  = cv_q && bus.cache_ready;
    pop_s    = (state_q == S_RUN) && (count_q != COUNT_ZERO) && (!cv_q || bus.cache_ready);

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    if (pop_s) begin
      cv_d    = 1'b1;
      caddr_d = addr_mem_q[rd_ptr_q];
      cop_d   = wr_mem_q[rd_ptr_q] ? OP_W : OP_R;
    end else if (issue_s) begin
      cv_d    = 1'b0;
      caddr_d = caddr_q;
      cop_d   = cop_q;
    end else begin
      cv_d    = cv_q;
      caddr_d = caddr_q;
      cop_d   = cop_q;
    end

    if (issue_s && (cop_q == OP_W)) begin
      wr_cnt_d = sat_inc(wr_cnt_q);
      rd_cnt_d = rd_cnt_q;
    end else if (issue_s) begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = sat_inc(rd_cnt_q);
    end else begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
    end

    if (accept_s && !(op_rd_s || op_wr_s)) begin
      bad_cnt_d = sat_inc(bad_cnt_q);
    end else begin
      bad_cnt_d = bad_cnt_q;
    end
  end

  // Control FSM next state and the sticky last-record flag.
  always_comb begin
    state_d = state_q;
    if (accept_s && bus.in_last) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (last_q && (count_d == COUNT_ZERO) && !cv_d) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
          last_d  = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_q[wr_ptr_q] <= bus.in_addr;
      wr_mem_q[wr_ptr_q]   <= op_wr_s;
    end
  end

  // Control and output state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      count_q   <= COUNT_ZERO;
      last_q    <= 1'b0;
      cv_q      <= 1'b0;
      caddr_q   <= {ADDR_W{1'b0}};
      cop_q     <= 8'h00;
      rd_cnt_q  <= CNT_ZERO;
      wr_cnt_q  <= CNT_ZERO;
      bad_cnt_q <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      cv_q      <= cv_d;
      caddr_q   <= caddr_d;
      cop_q     <= cop_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      bad_cnt_q <= bad_cnt_d;
    end
  end
endmodule

// File: tb/tb_cache_trace_feeder.sv
// Bench for cache_trace_feeder: directed vector table, multi-cycle corner sequences,
// counter saturation on a narrow-counter instance, and randomized traffic against a queue model.
module tb_cache_trace_feeder;
  localparam int DEPTH = 4;
  localparam int AW    = 48;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_trace_feeder_if #(.ADDR_W(AW), .CNT_W(18)) u_if ();
  cache_trace_feeder_if #(.ADDR_W(AW), .CNT_W(2))  s_if ();

  cache_trace_feeder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(18)) dut (
    .clk(clk), .reset(reset), .bus(u_if)
  );
  cache_trace_feeder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(s_if)
  );

  typedef struct {
    logic en, iv;
    logic [7:0] op;
    logic [AW-1:0] addr;
    logic last, cr;
    logic e_rdy, e_cv;
    logic [7:0] e_op;
    logic [AW-1:0] e_addr;
    int e_rd, e_wr, e_bad;
    logic e_done;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic wr;
  } rec_t;

  vec_t vt[10];
  rec_t mq[$];
  rec_t m_out;
  bit   m_valid, m_last;
  int   m_state, m_rd, m_wr, m_bad;

  function automatic vec_t mk(input logic en, iv, input logic [7:0] op, input logic [AW-1:0] addr,
                              input logic last, cr, e_rdy, e_cv, input logic [7:0] e_op,
                              input logic [AW-1:0] e_addr, input int e_rd, e_wr, e_bad,
                              input logic e_done);
    vec_t v;
    v.en = en; v.iv = iv; v.op = op; v.addr = addr; v.last = last; v.cr = cr;
    v.e_rdy = e_rdy; v.e_cv = e_cv; v.e_op = e_op; v.e_addr = e_addr;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_bad = e_bad; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.enable = 1'b0; u_if.in_valid = 1'b0; u_if.in_op = 8'h00;
    u_if.in_addr = '0;  u_if.in_last = 1'b0;  u_if.cache_ready = 1'b0;
    s_if.enable = 1'b0; s_if.in_valid = 1'b0; s_if.in_op = 8'h00;
    s_if.in_addr = '0;  s_if.in_last = 1'b0;  s_if.cache_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    mq.delete();
    m_valid = 1'b0; m_last = 1'b0; m_state = M_IDLE;
    m_rd = 0; m_wr = 0; m_bad = 0;
  endtask

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && (m_state != M_DONE);
  endfunction

  function automatic int sat18(input int v);
    return (v >= 32'h3FFFF) ? 32'h3FFFF : v + 1;
  endfunction

  // Reference: one clock edge of the feeder, using the inputs currently driven on u_if.
  task automatic model_step();
    bit acc, issue, load, good, old_last;
    acc      = u_if.in_valid && m_ready();
    issue    = m_valid && u_if.cache_ready;
    load     = (m_state == M_RUN) && (mq.size() > 0) && (!m_valid || u_if.cache_ready);
    good     = (u_if.in_op == 8'h52) || (u_if.in_op == 8'h72) ||
               (u_if.in_op == 8'h57) || (u_if.in_op == 8'h77);
    old_last = m_last;
    if (issue) begin
      if (m_out.wr) m_wr = sat18(m_wr);
      else          m_rd = sat18(m_rd);
    end
    if (load) begin
      m_out   = mq.pop_front();
      m_valid = 1'b1;
    end else if (issue) begin
      m_valid = 1'b0;
    end
    if (acc) begin
      if (good) mq.push_back('{addr: u_if.in_addr, wr: (u_if.in_op == 8'h57) || (u_if.in_op == 8'h77)});
      else      m_bad = sat18(m_bad);
      if (u_if.in_last) m_last = 1'b1;
    end
    if (m_state == M_IDLE) begin
      if (u_if.enable) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (!u_if.enable) m_state = M_IDLE;
      else if (old_last && mq.size() == 0 && !m_valid) m_state = M_DONE;
    end else begin
      if (!u_if.enable) begin
        m_state = M_IDLE;
        m_last  = 1'b0;
      end
    end
  endtask

  task automatic compare_model();
    chk1("rnd_in_ready", u_if.in_ready, m_ready());
    chk1("rnd_cache_valid", u_if.cache_valid, m_valid);
    if (m_valid) begin
      chkv("rnd_cache_addr", 64'(u_if.cache_addr), 64'(m_out.addr));
      chkv("rnd_cache_op", 64'(u_if.cache_op), m_out.wr ? 64'h57 : 64'h52);
    end
    chkv("rnd_reads", 64'(u_if.issued_reads), 64'(m_rd));
    chkv("rnd_writes", 64'(u_if.issued_writes), 64'(m_wr));
    chkv("rnd_bad", 64'(u_if.bad_ops), 64'(m_bad));
    chk1("rnd_done", u_if.done, m_state == M_DONE);
  endtask

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 9))
      0: return 8'h52;
      1: return 8'h72;
      2: return 8'h57;
      3: return 8'h77;
      4: return 8'h52;
      5: return 8'h57;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    #1;
    chk1("rst_in_ready", u_if.in_ready, 1'b0);
    chk1("rst_cache_valid", u_if.cache_valid, 1'b0);
    chk1("rst_done", u_if.done, 1'b0);
    chkv("rst_addr", 64'(u_if.cache_addr), 64'h0);
    chkv("rst_counters", 64'(u_if.issued_reads | u_if.issued_writes | u_if.bad_ops), 64'h0);
    #11;
    reset = 1'b0;
    #1;
    chk1("rst_release_ready", u_if.in_ready, 1'b1);

    // en iv op addr last cr | rdy cv op addr rd wr bad done
    vt[0] = mk(1, 0, 8'h00, 48'h0, 0, 1, 1, 0, 8'h00, 48'h0, 0, 0, 0, 0);
    vt[1] = mk(1, 1, 8'h52, 48'h0000_1234_5678, 0, 1, 1, 0, 8'h00, 48'h0, 0, 0, 0, 0);
    vt[2] = mk(1, 0, 8'h00, 48'h0, 0, 1, 1, 1, 8'h52, 48'h0000_1234_5678, 0, 0, 0, 0);
    vt[3] = mk(1, 0, 8'h00, 48'h0, 0, 1, 1, 0, 8'h00, 48'h0, 1, 0, 0, 0);
    vt[4] = mk(1, 1, 8'h77, 48'hA1, 0, 1, 1, 0, 8'h00, 48'h0, 1, 0, 0, 0);
    vt[5] = mk(1, 1, 8'h58, 48'hA2, 0, 1, 1, 1, 8'h57, 48'hA1, 1, 0, 1, 0);
    vt[6] = mk(1, 1, 8'h72, 48'hA3, 1, 1, 1, 0, 8'h00, 48'h0, 1, 1, 1, 0);
    vt[7] = mk(1, 0, 8'h00, 48'h0, 0, 1, 1, 1, 8'h52, 48'hA3, 1, 1, 1, 0);
    vt[8] = mk(1, 0, 8'h00, 48'h0, 0, 1, 0, 0, 8'h00, 48'h0, 2, 1, 1, 1);
    vt[9] = mk(0, 0, 8'h00, 48'h0, 0, 1, 1, 0, 8'h00, 48'h0, 2, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      u_if.enable = vt[i].en;  u_if.in_valid = vt[i].iv; u_if.in_op = vt[i].op;
      u_if.in_addr = vt[i].addr; u_if.in_last = vt[i].last; u_if.cache_ready = vt[i].cr;
      tick();
      chk1($sformatf("vec%0d_in_ready", i), u_if.in_ready, vt[i].e_rdy);
      chk1($sformatf("vec%0d_cache_valid", i), u_if.cache_valid, vt[i].e_cv);
      if (vt[i].e_cv) begin
        chkv($sformatf("vec%0d_cache_op", i), 64'(u_if.cache_op), 64'(vt[i].e_op));
        chkv($sformatf("vec%0d_cache_addr", i), 64'(u_if.cache_addr), 64'(vt[i].e_addr));
      end
      chkv($sformatf("vec%0d_reads", i), 64'(u_if.issued_reads), 64'(vt[i].e_rd));
      chkv($sformatf("vec%0d_writes", i), 64'(u_if.issued_writes), 64'(vt[i].e_wr));
      chkv($sformatf("vec%0d_bad", i), 64'(u_if.bad_ops), 64'(vt[i].e_bad));
      chk1($sformatf("vec%0d_done", i), u_if.done, vt[i].e_done);
    end

    // Backpressure: 4 records in the FIFO plus 1 held in the output register.
    do_reset();
    u_if.enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1("bp_ready_before_push", u_if.in_ready, 1'b1);
      u_if.in_valid = 1'b1;
      u_if.in_op    = (i % 2 == 1) ? 8'h57 : 8'h52;
      u_if.in_addr  = 48'h100 + 48'(i);
      tick();
    end
    u_if.in_valid = 1'b1;
    u_if.in_op    = 8'h52;
    u_if.in_addr  = 48'h1FF;
    for (int i = 0; i < 3; i++) begin
      chk1("bp_full_ready", u_if.in_ready, 1'b0);
      chk1("bp_hold_valid", u_if.cache_valid, 1'b1);
      chkv("bp_hold_addr", 64'(u_if.cache_addr), 64'h100);
      chkv("bp_hold_op", 64'(u_if.cache_op), 64'h52);
      tick();
    end
    u_if.in_valid    = 1'b0;
    u_if.cache_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk1("bp_drain_valid", u_if.cache_valid, 1'b1);
      chkv("bp_drain_addr", 64'(u_if.cache_addr), 64'h100 + 64'(i));
      chkv("bp_drain_op", 64'(u_if.cache_op), (i % 2 == 1) ? 64'h57 : 64'h52);
      if (i == 1) chk1("bp_ready_after_pop", u_if.in_ready, 1'b1);
    end
    tick();
    chk1("bp_drained", u_if.cache_valid, 1'b0);
    chkv("bp_reads", 64'(u_if.issued_reads), 64'd3);
    chkv("bp_writes", 64'(u_if.issued_writes), 64'd2);

    // Last flag carried by a dropped record.
    do_reset();
    u_if.enable = 1'b1;
    u_if.cache_ready = 1'b1;
    tick();
    u_if.in_valid = 1'b1; u_if.in_op = 8'h52; u_if.in_addr = 48'h300;
    tick();
    u_if.in_op = 8'h5A; u_if.in_addr = 48'h301; u_if.in_last = 1'b1;
    tick();
    chkv("lastdrop_addr", 64'(u_if.cache_addr), 64'h300);
    chkv("lastdrop_bad", 64'(u_if.bad_ops), 64'd1);
    u_if.in_valid = 1'b0; u_if.in_last = 1'b0;
    tick();
    chk1("lastdrop_done", u_if.done, 1'b1);
    chk1("lastdrop_ready", u_if.in_ready, 1'b0);
    tick();
    chkv("lastdrop_reads", 64'(u_if.issued_reads), 64'd1);
    chkv("lastdrop_writes", 64'(u_if.issued_writes), 64'd0);
    u_if.enable = 1'b0;
    tick();
    chk1("lastdrop_idle_done", u_if.done, 1'b0);
    chk1("lastdrop_idle_ready", u_if.in_ready, 1'b1);

    // Asynchronous reset between edges with records buffered and presented.
    do_reset();
    u_if.enable = 1'b1;
    tick();
    u_if.in_valid = 1'b1; u_if.in_op = 8'h51; u_if.in_addr = 48'h0;
    tick();
    for (int i = 0; i < 4; i++) begin
      u_if.in_op = 8'h52; u_if.in_addr = 48'h200 + 48'(i);
      tick();
    end
    u_if.in_valid = 1'b0;
    chk1("arst_pre_valid", u_if.cache_valid, 1'b1);
    chkv("arst_pre_bad", 64'(u_if.bad_ops), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk1("arst_valid", u_if.cache_valid, 1'b0);
    chk1("arst_ready", u_if.in_ready, 1'b0);
    chkv("arst_bad", 64'(u_if.bad_ops), 64'd0);
    chkv("arst_addr", 64'(u_if.cache_addr), 64'h0);
    reset = 1'b0;
    #1;
    chk1("arst_release_ready", u_if.in_ready, 1'b1);
    u_if.cache_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("arst_no_issue_valid", u_if.cache_valid, 1'b0);
    end
    chkv("arst_reads", 64'(u_if.issued_reads), 64'd0);

    // Saturation on the 2-bit counter instance.
    do_reset();
    s_if.enable = 1'b1;
    s_if.cache_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_if.in_valid = 1'b1;
      s_if.in_op    = (i < 5) ? 8'h57 : 8'h51;
      s_if.in_addr  = 48'(i);
      tick();
    end
    s_if.in_valid = 1'b0;
    repeat (4) tick();
    chkv("sat_writes", 64'(s_if.issued_writes), 64'd3);
    chkv("sat_bad", 64'(s_if.bad_ops), 64'd3);
    chkv("sat_reads", 64'(s_if.issued_reads), 64'd0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_state == M_DONE) u_if.enable = 1'($urandom_range(0, 1));
      else                   u_if.enable = ($urandom_range(0, 9) != 0);
      u_if.in_valid    = ($urandom_range(0, 3) != 0);
      u_if.in_op       = rand_op();
      u_if.in_addr     = {16'($urandom_range(0, 65535)), 32'($urandom)};
      u_if.in_last     = ($urandom_range(0, 39) == 0);
      u_if.cache_ready = ($urandom_range(0, 9) < 7);
      model_step();
      tick();
      compare_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
